// File: rtl/inst_decoder.sv
// inst_decoder: RV32I decode stage with register-file read handshake and execute hand-off
module inst_decoder #(
    parameter int LEN = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           rdy_in,
    input  logic           inst_valid,
    input  logic [31:0]    inst,
    input  logic [LEN-1:0] inst_pc,
    output logic           inst_ready,
    output logic           reg_ex_signal,
    output logic [4:0]     rs1,
    output logic [4:0]     rs2,
    input  logic [LEN-1:0] rs1_data,
    input  logic [LEN-1:0] rs2_data,
    output logic           dec_valid,
    input  logic           ex_ready,
    output logic [6:0]     dec_opcode,
    output logic [2:0]     dec_funct3,
    output logic [6:0]     dec_funct7,
    output logic [4:0]     dec_rd,
    output logic [LEN-1:0] dec_imm,
    output logic [LEN-1:0] dec_rs1_val,
    output logic [LEN-1:0] dec_rs2_val,
    output logic [LEN-1:0] dec_pc,
    output logic           dec_wb,
    output logic           illegal
);
    typedef enum logic [1:0] {IDLE, READ, WAIT, OUT} state_t;
    state_t state, state_next;
    logic [6:0] op;
    logic is_u, is_j, is_i, is_s, is_b, is_r, legal, wb_base;
    logic [31:0] imm32;
    logic [LEN-1:0] imm_ext;
    assign inst_ready = state == IDLE;
    assign reg_ex_signal = state == READ;
    assign dec_valid = state == OUT;
    // Classify the incoming opcode and build its sign-extended immediate
    always_comb begin
        op = inst[6:0];
        is_u = op == 7'b0110111 || op == 7'b0010111;
        is_j = op == 7'b1101111;
        is_i = op == 7'b1100111 || op == 7'b0000011 || op == 7'b0010011;
        is_r = op == 7'b0110011;
        is_b = op == 7'b1100011;
        is_s = op == 7'b0100011;
        legal = is_u | is_j | is_i | is_r | is_b | is_s;
        wb_base = is_u | is_j | is_i | is_r;
        imm32 = is_i ? {{20{inst[31]}}, inst[31:20]} :
                is_s ? {{20{inst[31]}}, inst[31:25], inst[11:7]} :
                is_b ? {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0} :
                is_u ? {inst[31:12], 12'b0} :
                is_j ? {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0} : '0;
        imm_ext = LEN'($signed(imm32));
    end
    // Next-state: accept in IDLE, one-cycle READ and WAIT, hold OUT until execute takes it
    always_comb begin
        state_next = state;
        case (state)
            IDLE: state_next = inst_valid ? (legal ? READ : OUT) : IDLE;
            READ: state_next = WAIT;
            WAIT: state_next = OUT;
            OUT:  state_next = ex_ready ? IDLE : OUT;
            default: state_next = IDLE;
        endcase
    end
    // State and bundle registers; everything freezes while rdy_in is low
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            rs1         <= '0;
            rs2         <= '0;
            dec_opcode  <= '0;
            dec_funct3  <= '0;
            dec_funct7  <= '0;
            dec_rd      <= '0;
            dec_imm     <= '0;
            dec_rs1_val <= '0;
            dec_rs2_val <= '0;
            dec_pc      <= '0;
            dec_wb      <= 1'b0;
            illegal     <= 1'b0;
        end else if (rdy_in) begin
            state <= state_next;
            if (state == IDLE && inst_valid) begin
                rs1         <= legal && !(is_u || is_j) ? inst[19:15] : 5'd0;
                rs2         <= is_s || is_b || is_r ? inst[24:20] : 5'd0;
                dec_opcode  <= op;
                dec_funct3  <= inst[14:12];
                dec_funct7  <= inst[31:25];
                dec_rd      <= inst[11:7];
                dec_imm     <= imm_ext;
                dec_rs1_val <= '0;
                dec_rs2_val <= '0;
                dec_pc      <= inst_pc;
                dec_wb      <= wb_base && inst[11:7] != 5'd0;
                illegal     <= !legal;
            end
            if (state == WAIT) begin
                dec_rs1_val <= rs1 == 5'd0 ? '0 : rs1_data;
                dec_rs2_val <= rs2 == 5'd0 ? '0 : rs2_data;
            end
        end
    end
endmodule

// File: doc/inst_decoder.md
INST_DECODER -- requirements
Module: inst_decoder

Interface
REQ-001 Parameter: LEN, default 32, data width of operand, immediate and PC buses.
REQ-002 clk  in  1  the one clock; all state updates on its rising edge.
REQ-003 rst  in  1  reset, synchronous and active-low (rst==0 at a rising clk edge resets the block).
REQ-004 rdy_in  in  1  global enable; when 0 all state and outputs freeze.
REQ-005 inst_valid  in  1  fetch presents an instruction.
REQ-006 inst  in  32  RV32I instruction word.
REQ-007 inst_pc  in  LEN  PC of inst.
REQ-008 inst_ready  out  1  decoder accepts an instruction this cycle.
REQ-009 reg_ex_signal  out  1  register-file read request.
REQ-010 rs1  out  5  register-file read index 1.
REQ-011 rs2  out  5  register-file read index 2.
REQ-012 rs1_data  in  LEN  register-file read data 1, valid the cycle after the request.
REQ-013 rs2_data  in  LEN  register-file read data 2, valid the cycle after the request.
REQ-014 dec_valid  out  1  decoded bundle valid for execute.
REQ-015 ex_ready  in  1  execute consumes the bundle.
REQ-016 dec_opcode  out  7;  dec_funct3  out  3;  dec_funct7  out  7;  dec_rd  out  5  decoded fields.
REQ-017 dec_imm  out  LEN;  dec_rs1_val  out  LEN;  dec_rs2_val  out  LEN;  dec_pc  out  LEN  operands, immediate and PC.
REQ-018 dec_wb  out  1;  illegal  out  1  write-back required; unsupported opcode.

Function
REQ-019 The FSM SHALL have the states IDLE, READ, WAIT and OUT.
REQ-020 inst_ready SHALL be 1 only in IDLE.
- Handshake: inst_valid && inst_ready latches inst and inst_pc.
- Next state: READ for a legal opcode; OUT with illegal=1 otherwise.
REQ-021 READ SHALL last one cycle.
- reg_ex_signal=1 only in READ.
- rs1/rs2 driven from the latched instruction; next state is WAIT.
REQ-022 WAIT SHALL last one cycle.
- Captures rs1_data/rs2_data into dec_rs1_val/dec_rs2_val; next state is OUT.
REQ-023 OUT SHALL assert dec_valid and hold every dec_* output stable until ex_ready=1, then go to IDLE.
REQ-024 Latency SHALL be 3 cycles from the accept edge to dec_valid=1 for legal instructions, and 1 cycle for illegal ones.
REQ-025 Legal opcodes, with format and dec_wb base value:
- LUI 0110111 U wb; AUIPC 0010111 U wb; JAL 1101111 J wb; JALR 1100111 I wb; LOAD 0000011 I wb; OP-IMM 0010011 I wb.
- OP 0110011 R wb; BRANCH 1100011 B no-wb; STORE 0100011 S no-wb.
REQ-026 dec_wb SHALL be the base value AND (rd!=0).
REQ-027 Immediates SHALL be sign-extended to LEN bits.
- I: inst[31:20]; S: {inst[31:25],inst[11:7]}; B: {inst[31],inst[7],inst[30:25],inst[11:8],0}.
- U: {inst[31:12],12'b0}; J: {inst[31],inst[19:12],inst[20],inst[30:21],0}; R: 0.
REQ-028 rs1 SHALL be 0 for U/J formats; rs2 SHALL be 0 for U/J/I formats.
REQ-029 dec_rs1_val/dec_rs2_val SHALL be forced to 0 when the corresponding index is 0, regardless of rs*_data.
REQ-030 For an illegal instruction: reg_ex_signal is never asserted; dec_imm, dec_rs*_val and dec_wb are 0; dec_opcode/funct/pc carry the raw fields.
REQ-031 With rdy_in=0 the FSM SHALL hold its state and all outputs, including reg_ex_signal, and SHALL not latch inputs or consume ex_ready.
REQ-032 An inst_valid arriving outside IDLE SHALL be ignored (not latched) until inst_ready=1.

Reset
REQ-033 rst==0 at any edge SHALL force IDLE from any state, discarding any in-flight instruction.
REQ-034 Reset values SHALL be: inst_ready=1, reg_ex_signal=0, dec_valid=0, illegal=0, dec_wb=0, and all other outputs 0.

Verification
REQ-035 Bench: accept ADDI x5,x3,-1 (0xFFF18293), rs1_data=0x10 the cycle after READ -> reg_ex_signal pulses one cycle with rs1=3, rs2=0; 3 cycles later dec_valid=1, dec_imm=0xFFFFFFFF, dec_rs1_val=0x10, dec_rd=5, dec_wb=1.
REQ-036 Bench: BEQ offset -4 (0xFE000EE3) -> dec_imm=0xFFFFFFFC, dec_wb=0, rs1=rs2=0 so dec_rs1_val=dec_rs2_val=0 even with rs*_data=0xDEAD.
REQ-037 Bench: opcode 0x7F (0x0000007F) -> dec_valid=1 one cycle after accept, illegal=1, reg_ex_signal never 1.
REQ-038 Bench: hold ex_ready=0 for 5 cycles in OUT, while toggling rs1_data and inst_valid -> bundle unchanged, inst_ready=0; ex_ready=1 -> IDLE next cycle.
REQ-039 Bench: drive rdy_in=0 for 3 cycles while in READ -> reg_ex_signal stays 1 and the state is unchanged; resume -> WAIT proceeds normally.
REQ-040 Bench: rst=0 during WAIT -> next cycle dec_valid=0, inst_ready=1, and no bundle is ever emitted for that instruction.
